// File: rtl/lemming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lemming_pkg                                                          |
// | Phase encoding, event codes, FIFO entry type, saturating helpers.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lemming_pkg;

  typedef enum logic [2:0] {
    PH_WALK_L = 3'd0,
    PH_WALK_R = 3'd1,
    PH_DIG    = 3'd2,
    PH_FALL   = 3'd3,
    PH_NONE   = 3'd4
  } phase_t;

  localparam logic [2:0] c_evt_turn_r     = 3'd0;
  localparam logic [2:0] c_evt_turn_l     = 3'd1;
  localparam logic [2:0] c_evt_dig_start  = 3'd2;
  localparam logic [2:0] c_evt_fall_start = 3'd3;
  localparam logic [2:0] c_evt_land       = 3'd4;
  localparam logic [2:0] c_evt_splat      = 3'd5;
  localparam logic [2:0] c_evt_err        = 3'd6;

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
  } evt_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec8(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lemming_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lemming_evt_fifo                                                     |
// | Shift-register event FIFO; the head is always entry 0 (registered).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lemming_evt_fifo
  import lemming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  evt_entry_t i_data,
  output logic       o_full,
  input  logic       i_pop,
  output logic       o_empty,
  output evt_entry_t o_head
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  evt_entry_t     r_mem [FIFO_DEPTH];
  evt_entry_t     w_up  [FIFO_DEPTH];
  logic [CW-1:0]  r_count;
  logic           r_empty;
  logic           w_pop;
  logic           w_push;
  logic [CW-1:0]  w_wr_idx;
  logic [CW-1:0]  w_count_nxt;

  assign w_pop       = i_pop && !r_empty;
  assign o_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = i_push && (!o_full || w_pop);
  assign w_wr_idx    = r_count - CW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Entry that slides into each slot on a pop; the tail refills with zero.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_shift
    if (gi == FIFO_DEPTH - 1) begin : g_tail
      assign w_up[gi] = '0;
    end else begin : g_body
      assign w_up[gi] = r_mem[gi+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_empty <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (w_wr_idx == CW'(i))) r_mem[i] <= i_data;
        else if (w_pop)                     r_mem[i] <= w_up[i];
      end
    end
  end

  assign o_empty = r_empty;
  assign o_head  = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/lemming_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lemming_monitor                                                      |
// | Tracks lemming phase/position and queues phase-transition events.    |
// | Optional statistics counters: define LEMMING_MON_STATS_EN.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lemming_monitor
  import lemming_pkg::*;
#(
  parameter logic [7:0] POS_X_INIT = 8'd128,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        walk_left,
  input  logic        walk_right,
  input  logic        aaah,
  input  logic        digging,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic [2:0]  evt_code,
  output logic [7:0]  evt_data,
  output logic [7:0]  pos_x,
  output logic [7:0]  pos_y,
  output logic [7:0]  last_fall_len,
  output logic        dead,
  output logic        evt_overflow,
  output logic [15:0] turn_cnt,
  output logic [15:0] fall_cnt
);

  phase_t     r_prev, w_prev_nxt, w_cur;
  logic [7:0] r_pos_x, r_pos_y, r_fall_len, r_last_fall;
  logic [7:0] w_pos_x_nxt, w_pos_y_nxt, w_fall_nxt, w_last_nxt;
  logic       r_dead, w_dead_nxt, r_overflow;
  logic       w_legal, w_evt_vld, w_full, w_empty, w_drop;
  evt_entry_t w_evt, w_head;

  always_comb begin
    w_legal = 1'b1;
    case ({walk_left, walk_right, digging, aaah})
      4'b1000: w_cur = PH_WALK_L;
      4'b0100: w_cur = PH_WALK_R;
      4'b0010: w_cur = PH_DIG;
      4'b0001: w_cur = PH_FALL;
      4'b0000: w_cur = PH_NONE;
      default: begin w_cur = PH_NONE; w_legal = 1'b0; end
    endcase
  end

  always_comb begin
    w_evt_vld   = 1'b0;
    w_evt.code  = c_evt_err;
    w_evt.data  = r_pos_x;
    w_prev_nxt  = r_prev;
    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    w_fall_nxt  = r_fall_len;
    w_last_nxt  = r_last_fall;
    w_dead_nxt  = r_dead;
    if (!r_dead) begin
      // Walking straight into "nothing" cannot happen for a live lemming.
      if (!w_legal || (w_cur == PH_NONE && r_prev != PH_FALL && r_prev != PH_NONE)) begin
        w_evt_vld = 1'b1;
      end else begin
        w_prev_nxt = w_cur;
        w_fall_nxt = '0;
        case (w_cur)
          PH_WALK_L: begin
            w_pos_x_nxt = sat_dec8(r_pos_x);
            if (r_prev == PH_WALK_R) begin w_evt_vld = 1'b1; w_evt.code = c_evt_turn_l; end
            else if (r_prev == PH_FALL) begin w_evt_vld = 1'b1; w_evt.code = c_evt_land; end
          end
          PH_WALK_R: begin
            w_pos_x_nxt = sat_inc8(r_pos_x);
            if (r_prev == PH_WALK_L) begin w_evt_vld = 1'b1; w_evt.code = c_evt_turn_r; end
            else if (r_prev == PH_FALL) begin w_evt_vld = 1'b1; w_evt.code = c_evt_land; end
          end
          PH_DIG: begin
            w_pos_y_nxt = sat_inc8(r_pos_y);
            if (r_prev == PH_WALK_L || r_prev == PH_WALK_R) begin
              w_evt_vld = 1'b1; w_evt.code = c_evt_dig_start;
            end
          end
          PH_FALL: begin
            w_pos_y_nxt = sat_inc8(r_pos_y);
            w_fall_nxt  = sat_inc8(r_fall_len);
            if (r_prev != PH_FALL && r_prev != PH_NONE) begin
              w_evt_vld = 1'b1; w_evt.code = c_evt_fall_start;
            end
          end
          default: begin
            if (r_prev == PH_FALL) begin
              w_evt_vld = 1'b1; w_evt.code = c_evt_splat; w_dead_nxt = 1'b1;
            end
          end
        endcase
        if (w_evt_vld && (w_evt.code == c_evt_land || w_evt.code == c_evt_splat)) begin
          w_evt.data = r_fall_len;
          w_last_nxt = r_fall_len;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_prev      <= PH_WALK_L;
      r_pos_x     <= POS_X_INIT;
      r_pos_y     <= '0;
      r_fall_len  <= '0;
      r_last_fall <= '0;
      r_dead      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_prev      <= w_prev_nxt;
      r_pos_x     <= w_pos_x_nxt;
      r_pos_y     <= w_pos_y_nxt;
      r_fall_len  <= w_fall_nxt;
      r_last_fall <= w_last_nxt;
      r_dead      <= w_dead_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_drop = w_evt_vld && w_full && !(evt_ready && !w_empty);

  lemming_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (areset),
    .i_push  (w_evt_vld),
    .i_data  (w_evt),
    .o_full  (w_full),
    .i_pop   (evt_ready),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef LEMMING_MON_STATS_EN
  logic [15:0] r_turn_cnt, r_fall_cnt;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_turn_cnt <= '0;
      r_fall_cnt <= '0;
    end else if (w_evt_vld) begin
      if ((w_evt.code == c_evt_turn_r || w_evt.code == c_evt_turn_l) && r_turn_cnt != 16'hFFFF)
        r_turn_cnt <= r_turn_cnt + 16'd1;
      if (w_evt.code == c_evt_fall_start && r_fall_cnt != 16'hFFFF)
        r_fall_cnt <= r_fall_cnt + 16'd1;
    end
  end

  assign turn_cnt = r_turn_cnt;
  assign fall_cnt = r_fall_cnt;
`else
  assign turn_cnt = '0;
  assign fall_cnt = '0;
`endif

  assign evt_valid     = !w_empty;
  assign evt_code      = w_head.code;
  assign evt_data      = w_head.data;
  assign pos_x         = r_pos_x;
  assign pos_y         = r_pos_y;
  assign last_fall_len = r_last_fall;
  assign dead          = r_dead;
  assign evt_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lemming_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lemming_monitor                                                   |
// | Directed scenarios plus random status/ready against a queue model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lemming_monitor;

  localparam int DEPTH = 4;

  localparam logic [3:0] S_WL   = 4'b1000;  // {walk_left, walk_right, digging, aaah}
  localparam logic [3:0] S_WR   = 4'b0100;
  localparam logic [3:0] S_DIG  = 4'b0010;
  localparam logic [3:0] S_FALL = 4'b0001;
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_BAD  = 4'b1100;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid, dead, evt_overflow;
  logic [2:0]  evt_code;
  logic [7:0]  evt_data, pos_x, pos_y, last_fall_len;
  logic [15:0] turn_cnt, fall_cnt;

  lemming_monitor #(.POS_X_INIT(8'd128), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah), .digging(digging),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code), .evt_data(evt_data),
    .pos_x(pos_x), .pos_y(pos_y), .last_fall_len(last_fall_len), .dead(dead),
    .evt_overflow(evt_overflow), .turn_cnt(turn_cnt), .fall_cnt(fall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases 0=WL 1=WR 2=DIG 3=FALL 4=NONE, -1 illegal.
  typedef struct { int code; int data; } ev_t;
  ev_t m_q[$];
  int  m_px = 128, m_py = 0, m_prev = 0, m_fl = 0, m_last = 0, m_tc = 0, m_fc = 0;
  bit  m_dead = 0, m_ovf = 0;

  function automatic int classify(input logic [3:0] st);
    case (st)
      S_WL:    return 0;
      S_WR:    return 1;
      S_DIG:   return 2;
      S_FALL:  return 3;
      S_NONE:  return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int event_of(input int p, input int c);
    if (p == 0 && c == 1) return 0;
    if (p == 1 && c == 0) return 1;
    if (p <= 1 && c == 2) return 2;
    if (p <= 2 && c == 3) return 3;
    if (p == 3 && c <= 1) return 4;
    if (p == 3 && c == 4) return 5;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] st, input bit rdy, input bit rst);
    int  c, ev, d;
    bit  pop, full;
    ev_t e;
    if (rst) begin
      m_q.delete();
      m_px = 128; m_py = 0; m_prev = 0; m_fl = 0; m_last = 0;
      m_dead = 0; m_ovf = 0; m_tc = 0; m_fc = 0;
      return;
    end
    pop  = rdy && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    ev = -1; d = 0;
    if (!m_dead) begin
      c = classify(st);
      if (c < 0 || (c == 4 && m_prev != 3 && m_prev != 4)) begin
        ev = 6; d = m_px;
      end else begin
        ev = event_of(m_prev, c);
        d  = m_px;
        if (ev == 4 || ev == 5) begin d = m_fl; m_last = m_fl; end
        if (ev == 5) m_dead = 1;
        if (c == 0 && m_px > 0)   m_px--;
        if (c == 1 && m_px < 255) m_px++;
        if ((c == 2 || c == 3) && m_py < 255) m_py++;
        m_fl   = (c == 3) ? ((m_fl < 255) ? m_fl + 1 : 255) : 0;
        m_prev = c;
      end
      if ((ev == 0 || ev == 1) && m_tc < 65535) m_tc++;
      if (ev == 3 && m_fc < 65535) m_fc++;
    end
    if (pop) void'(m_q.pop_front());
    if (ev >= 0) begin
      if (full && !pop) m_ovf = 1;
      else begin e.code = ev; e.data = d; m_q.push_back(e); end
    end
  endtask

  task automatic compare_all();
    int exp_tc, exp_fc;
`ifdef LEMMING_MON_STATS_EN
    exp_tc = m_tc; exp_fc = m_fc;
`else
    exp_tc = 0; exp_fc = 0;
`endif
    check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("evt_code", 32'(evt_code), 32'(m_q[0].code));
      check("evt_data", 32'(evt_data), 32'(m_q[0].data));
    end
    check("pos_x", 32'(pos_x), 32'(m_px));
    check("pos_y", 32'(pos_y), 32'(m_py));
    check("last_fall_len", 32'(last_fall_len), 32'(m_last));
    check("dead", 32'(dead), 32'(m_dead));
    check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    check("turn_cnt", 32'(turn_cnt), 32'(exp_tc));
    check("fall_cnt", 32'(fall_cnt), 32'(exp_fc));
  endtask

  // Drive at a falling edge, let one rising edge sample, compare at the next falling edge.
  task automatic step(input logic [3:0] st, input bit rdy, input bit rst);
    {walk_left, walk_right, digging, aaah} = st;
    evt_ready = rdy;
    areset    = rst;
    model_step(st, rdy, rst);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input bit rdy);
    step(S_NONE, rdy, 1'b1);
    step(S_WL, rdy, 1'b1);
  endtask

  function automatic logic [3:0] rand_status();
    int r;
    logic [3:0] b;
    r = $urandom_range(0, 99);
    if (r < 25) return S_WL;
    if (r < 50) return S_WR;
    if (r < 65) return S_DIG;
    if (r < 88) return S_FALL;
    if (r < 94) return S_NONE;
    do b = 4'($urandom_range(0, 15)); while (classify(b) >= 0);
    return b;
  endfunction

  initial begin
    logic [3:0] cur;
    logic [2:0] exp_codes [4];
    int dead_cycles;
    int ready_pct;

    @(negedge clk);

    // Reset values
    do_reset(1'b0);
    check("rst_pos_x", 32'(pos_x), 32'd128);
    check("rst_pos_y", 32'(pos_y), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);
    check("rst_turn_cnt", 32'(turn_cnt), 32'd0);

    // Walk left five cycles: no events
    for (int i = 0; i < 5; i++) begin
      step(S_WL, 1'b0, 1'b0);
      check("wl_no_evt", 32'(evt_valid), 32'd0);
    end
    check("wl5_pos_x", 32'(pos_x), 32'd123);
    check("wl5_pos_y", 32'(pos_y), 32'd0);

    // Turn right: event visible right after the sampling edge
    do_reset(1'b0);
    step(S_WL, 1'b0, 1'b0);
    step(S_WL, 1'b0, 1'b0);
    check("turn_pre_valid", 32'(evt_valid), 32'd0);
    step(S_WR, 1'b0, 1'b0);
    check("turn_valid", 32'(evt_valid), 32'd1);
    check("turn_code", 32'(evt_code), 32'd0);
    check("turn_data", 32'(evt_data), 32'd126);

    // Fall 21 cycles then splat
    do_reset(1'b0);
    step(S_WL, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) step(S_FALL, 1'b0, 1'b0);
    step(S_NONE, 1'b0, 1'b0);
    check("splat_dead", 32'(dead), 32'd1);
    check("splat_last", 32'(last_fall_len), 32'd21);
    check("splat_pos_y", 32'(pos_y), 32'd21);
    check("splat_head", 32'(evt_code), 32'd3);
    step(S_NONE, 1'b1, 1'b0);
    check("splat_code", 32'(evt_code), 32'd5);
    check("splat_data", 32'(evt_data), 32'd21);
    for (int i = 0; i < 6; i++) step(rand_status(), 1'b1, 1'b0);
    check("dead_quiet", 32'(evt_valid), 32'd0);

    // Overflow with ready low, then ordered drain
    do_reset(1'b0);
    step(S_WL, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(S_WR, 1'b0, 1'b0);
      if (i < 2) step(S_WL, 1'b0, 1'b0);
    end
    check("ovf_flag", 32'(evt_overflow), 32'd1);
    exp_codes = '{3'd0, 3'd1, 3'd0, 3'd1};
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(evt_valid), 32'd1);
      check("drain_code", 32'(evt_code), 32'(exp_codes[k]));
      step(S_WR, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(evt_valid), 32'd0);

    // Illegal status
    do_reset(1'b0);
    step(S_WL, 1'b0, 1'b0);
    step(S_BAD, 1'b0, 1'b0);
    check("err_code", 32'(evt_code), 32'd6);
    check("err_data", 32'(evt_data), 32'd127);
    check("err_pos_x", 32'(pos_x), 32'd127);
    step(S_WR, 1'b0, 1'b0);
    check("err_prev_kept_pos", 32'(pos_x), 32'd128);

    // Statistics: 3 turns, 1 fall
    do_reset(1'b1);
    step(S_WR, 1'b1, 1'b0);
    step(S_WL, 1'b1, 1'b0);
    step(S_WR, 1'b1, 1'b0);
    step(S_FALL, 1'b1, 1'b0);
`ifdef LEMMING_MON_STATS_EN
    check("stat_turn", 32'(turn_cnt), 32'd3);
    check("stat_fall", 32'(fall_cnt), 32'd1);
`else
    check("stat_turn", 32'(turn_cnt), 32'd0);
    check("stat_fall", 32'(fall_cnt), 32'd0);
`endif

    // Random traffic
    do_reset(1'b0);
    cur = S_WL;
    dead_cycles = 0;
    ready_pct = 80;
    for (int n = 0; n < 4000; n++) begin
      if (n % 60 == 0) ready_pct = ($urandom_range(0, 1) != 0) ? 85 : 15;
      if ($urandom_range(0, 99) < 30) cur = rand_status();
      if (m_dead) dead_cycles++;
      else dead_cycles = 0;
      if (dead_cycles > 8 || $urandom_range(0, 199) == 0) begin
        step(cur, 1'b0, 1'b1);
        dead_cycles = 0;
      end else begin
        step(cur, ($urandom_range(0, 99) < ready_pct), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lemming_monitor.md
LEMMING_MONITOR -- requirements
Module: lemming_monitor

Interface
REQ-001 Parameter POS_X_INIT, default 128, is the 8-bit horizontal start position.
REQ-002 Parameter FIFO_DEPTH, default 4, is the event FIFO depth (power of two, 2..16).
REQ-003 The clock port SHALL be `clk`, input, 1 bit; the single clock, rising edge.
REQ-004 The reset port SHALL be `areset`, input, 1 bit; one clock; reset is synchronous and active-high.
REQ-005 `walk_left`, `walk_right`, `aaah` and `digging` SHALL each be a 1-bit input carrying the lemming FSM status.
REQ-006 `evt_ready`, input, 1 bit: the downstream consumer accepts the event.
REQ-007 `evt_valid`, output, 1 bit: the FIFO head is valid.
REQ-008 `evt_code`, output, 3 bits: the event type of the FIFO head.
REQ-009 `evt_data`, output, 8 bits: pos_x, or the fall length for LAND/SPLAT.
REQ-010 `pos_x` and `pos_y`, outputs, 8 bits each: tracked position; pos_y is depth.
REQ-011 `last_fall_len`, output, 8 bits: the length of the most recent completed fall.
REQ-012 `dead`, output, 1 bit: sticky splat flag.
REQ-013 `evt_overflow`, output, 1 bit: sticky flag, set when an event is dropped.
REQ-014 `turn_cnt` and `fall_cnt`, outputs, 16 bits each: statistics counters.

Function
REQ-015 All outputs SHALL be registered; inputs are sampled on every rising `clk` edge.
REQ-016 Legal status SHALL be exactly one status input high, or all low; any other combination is illegal.
REQ-017 Each legal sample SHALL classify as a phase: WALK_L, WALK_R, DIG (digging), FALL (aaah), or NONE (all low).
REQ-018 The previous phase SHALL be held in a register; at most one event is generated per cycle, from the (prev, cur) pair.
REQ-019 Events: WALK_L->WALK_R gives TURN_R (code 0); WALK_R->WALK_L gives TURN_L (1).
REQ-020 Events: WALK_x->DIG gives DIG_START (2); WALK_x or DIG->FALL gives FALL_START (3).
REQ-021 Events: FALL->WALK_x gives LAND (4); FALL->NONE gives SPLAT (5).
REQ-022 An illegal sample, or NONE with a previous phase other than FALL or NONE, SHALL give ERR (6).
REQ-023 An ERR sample SHALL NOT update prev or the position.
REQ-024 Position updates: WALK_L decrements pos_x, saturating at 0; WALK_R increments pos_x, saturating at 255.
REQ-025 Position updates: DIG or FALL increments pos_y, saturating at 255; NONE holds the position.
REQ-026 fall_len SHALL count consecutive FALL cycles, saturating at 255.
REQ-027 On LAND or SPLAT, last_fall_len and evt_data SHALL take fall_len, and fall_len SHALL clear.
REQ-028 evt_data SHALL be the pos_x value from before the update for all other events.
REQ-029 SPLAT SHALL set `dead`; while dead, no further events, position updates or ERR are generated.
REQ-030 A generated event SHALL be pushed on the sampling edge, so evt_valid rises the following cycle, with no bypass.
REQ-031 A pop SHALL occur on an edge where evt_valid and evt_ready are both high; evt_code and evt_data are stable while evt_valid is high and the event is not accepted.
REQ-032 When the FIFO is full, a push without a pop SHALL drop the new event and set evt_overflow.
REQ-033 When the FIFO is full, a simultaneous push and pop SHALL accept both.
REQ-034 evt_ready while the FIFO is empty SHALL have no effect.
REQ-035 Events SHALL leave the FIFO in generation order.

Reset
REQ-036 On areset: pos_x=POS_X_INIT, pos_y=0, prev=WALK_L, fall_len=0, last_fall_len=0, dead=0.
REQ-037 On areset: FIFO empty (evt_valid=0, evt_code=0, evt_data=0), evt_overflow=0, counters=0.
REQ-038 Reset mid-operation SHALL discard the FIFO contents and any event sampled on that edge.

Configuration
REQ-039 Macro LEMMING_MON_STATS_EN defined: turn_cnt counts TURN_L/TURN_R and fall_cnt counts FALL_START, each 16-bit saturating.
REQ-040 Macro LEMMING_MON_STATS_EN undefined: the ports SHALL remain present and tied to 0, with no counter logic.

Structure
REQ-041 Package lemming_pkg SHALL hold the phase enum, the event code constants (0..6) and the FIFO entry struct {code[2:0], data[7:0]}.
REQ-042 The FIFO SHALL be sub-module lemming_evt_fifo (parameter FIFO_DEPTH; push/full, pop/empty, synchronous reset).

Verification
REQ-043 Reset, then walk_left for 5 cycles -> pos_x=123, pos_y=0, evt_valid stays 0.
REQ-044 Reset, walk_left for 2 cycles, then walk_right -> one event TURN_R with data=126, evt_valid rising one cycle after the walk_right sample.
REQ-045 Walk, then aaah for 21 cycles, then all low -> FALL_START, then SPLAT with data=21; dead=1, last_fall_len=21, pos_y=21, and no further events on later inputs.
REQ-046 evt_ready=0 with 5 turns generated -> 4 events held, evt_overflow=1; draining returns TURN_R, TURN_L, TURN_R, TURN_L in order.
REQ-047 walk_left and walk_right high together -> ERR with data equal to the current pos_x; position and prev are unchanged.
REQ-048 With LEMMING_MON_STATS_EN, 3 turns and 1 fall -> turn_cnt=3, fall_cnt=1; without the macro, both read 0.
